// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the Y86 pipeline control unit:
// icodes, register-none id, PC-source selects and FSM state encodings.
package pipe_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [7:0] RNONE = 8'h0F;

  localparam logic [1:0] PC_PRED    = 2'd0;
  localparam logic [1:0] PC_MISPRED = 2'd1;
  localparam logic [1:0] PC_RET     = 2'd2;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_RET_WAIT = 2'd1;
  localparam logic [1:0] S_HALTED   = 2'd2;

  // Bubbled cycles still to go once a ret leaves D (D->E->M->W).
  localparam logic [1:0] RET_CNT_INIT = 2'd2;

  typedef struct packed {
    logic stop;
    logic mispred;
    logic load_use;
    logic ret_d;
  } hazard_t;

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVL) || (icode == I_POPL);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side bundle for pipe_ctrl: stage observations in, stall/bubble
// strobes, PC select and performance counters out.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic [7:0]       d_icode, d_srcA, d_srcB;
  logic [7:0]       e_icode, e_dstM;
  logic             e_cnd, m_err;
  logic [7:0]       w_icode;
  logic             w_err;
  logic             f_stall, d_stall, w_stall;
  logic             d_bubble, e_bubble, m_bubble;
  logic [1:0]       pc_sel;
  logic             halted;
  logic [CNT_W-1:0] perf_stall, perf_bubble, perf_mispred;

  modport master (
    output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_err, w_icode, w_err,
    input  f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, pc_sel, halted,
    input  perf_stall, perf_bubble, perf_mispred
  );

  modport slave (
    input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cnd, m_err, w_icode, w_err,
    output f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, pc_sel, halted,
    output perf_stall, perf_bubble, perf_mispred
  );
endinterface

// File: rtl/pipe_hazard_det.sv
// Combinational hazard flags for pipe_ctrl: load-use, mispredict,
// ret sitting in D, and stop (halt or error reaching W).
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [7:0] d_icode_i,
  input  logic [7:0] d_srcA_i,
  input  logic [7:0] d_srcB_i,
  input  logic [7:0] e_icode_i,
  input  logic [7:0] e_dstM_i,
  input  logic       e_cnd_i,
  input  logic [7:0] w_icode_i,
  input  logic       w_err_i,
  output hazard_t    haz_o
);

  // Only the low nibble of an icode carries the instruction.
  logic unused_icode_hi;
  assign unused_icode_hi = ^{d_icode_i[7:4], e_icode_i[7:4], w_icode_i[7:4]};

  always_comb begin
    haz_o          = '0;
    haz_o.load_use = is_load(e_icode_i[3:0]) && (e_dstM_i != RNONE) &&
                     ((e_dstM_i == d_srcA_i) || (e_dstM_i == d_srcB_i));
    haz_o.mispred  = (e_icode_i[3:0] == I_JXX) && !e_cnd_i;
    haz_o.ret_d    = (d_icode_i[3:0] == I_RET);
    haz_o.stop     = (w_icode_i[3:0] == I_HALT) || w_err_i;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86 core: hazard priority, ret/halt
// FSM and optional performance counters (enabled by PIPE_CTRL_PERF_EN).
//
// state      | meaning
// RUN        | normal flow; hazards resolved by priority each cycle
// RET_WAIT   | ret travelling D->W, fetch held; ret_cnt counts bubbles left
// HALTED     | halt or error reached W; everything held until reset
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic [1:0] ret_cnt_q, ret_cnt_d;
  hazard_t    haz;

  logic       f_stall, d_stall, w_stall;
  logic       d_bubble, e_bubble, m_bubble;
  logic [1:0] pc_sel;
  logic       halted, go_halt, mp_taken;

  pipe_hazard_det u_haz (
    .d_icode_i (bus.d_icode),
    .d_srcA_i  (bus.d_srcA),
    .d_srcB_i  (bus.d_srcB),
    .e_icode_i (bus.e_icode),
    .e_dstM_i  (bus.e_dstM),
    .e_cnd_i   (bus.e_cnd),
    .w_icode_i (bus.w_icode),
    .w_err_i   (bus.w_err),
    .haz_o     (haz)
  );

  always_comb begin
    state_d   = state_q;
    ret_cnt_d = ret_cnt_q;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    w_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    m_bubble  = 1'b0;
    pc_sel    = PC_PRED;
    halted    = 1'b0;
    go_halt   = 1'b0;
    mp_taken  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (haz.stop) begin
          go_halt = 1'b1;
        end else if (haz.mispred) begin
          d_bubble = 1'b1;
          e_bubble = 1'b1;
          pc_sel   = PC_MISPRED;
          mp_taken = 1'b1;
        end else if (haz.load_use) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end else if (haz.ret_d) begin
          f_stall   = 1'b1;
          d_bubble  = 1'b1;
          state_d   = S_RET_WAIT;
          ret_cnt_d = RET_CNT_INIT;
        end
        if (bus.m_err || bus.w_err) m_bubble = 1'b1;
      end
      S_RET_WAIT: begin
        if (haz.stop) begin
          go_halt = 1'b1;
        end else if (ret_cnt_q != 2'd0) begin
          f_stall   = 1'b1;
          d_bubble  = 1'b1;
          ret_cnt_d = ret_cnt_q - 2'd1;
        end else begin
          pc_sel  = PC_RET;
          state_d = S_RUN;
        end
      end
      default: go_halt = 1'b1;
    endcase
    // Halt outputs replace whatever the case above produced.
    if (go_halt) begin
      state_d   = S_HALTED;
      ret_cnt_d = 2'd0;
      f_stall   = 1'b1;
      d_stall   = 1'b1;
      w_stall   = 1'b1;
      d_bubble  = 1'b0;
      e_bubble  = 1'b1;
      m_bubble  = 1'b1;
      pc_sel    = PC_PRED;
      halted    = 1'b1;
      mp_taken  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      ret_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign bus.f_stall  = rst & f_stall;
  assign bus.d_stall  = rst & d_stall;
  assign bus.w_stall  = rst & w_stall;
  assign bus.d_bubble = rst & d_bubble;
  assign bus.e_bubble = rst & e_bubble;
  assign bus.m_bubble = rst & m_bubble;
  assign bus.pc_sel   = rst ? pc_sel : PC_PRED;
  assign bus.halted   = rst & halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_bubble_q, perf_mispred_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q   <= '0;
      perf_bubble_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (f_stall && (state_q != S_HALTED))  perf_stall_q  <= perf_stall_q + 1'b1;
      if (e_bubble && (state_q != S_HALTED)) perf_bubble_q <= perf_bubble_q + 1'b1;
      if (mp_taken)                           perf_mispred_q <= perf_mispred_q + 1'b1;
    end
  end

  assign bus.perf_stall   = perf_stall_q;
  assign bus.perf_bubble  = perf_bubble_q;
  assign bus.perf_mispred = perf_mispred_q;
`else
  logic unused_perf;
  assign unused_perf      = mp_taken;
  assign bus.perf_stall   = {CNT_W{1'b0}};
  assign bus.perf_bubble  = {CNT_W{1'b0}};
  assign bus.perf_mispred = {CNT_W{1'b0}};
`endif

endmodule
